// File: rtl/anfsqrt_pdm_341449297858921043.sv
`default_nettype none
// ============================================================================
// Module   : anfsqrt_pdm_341449297858921043
// Brief    : First-order sigma-delta PDM with a double-buffered sample input;
//            every 2^WIDTH-cycle frame carries exactly 'active' high bits.
// Revision : 1.0 - initial release
// ============================================================================
module anfsqrt_pdm_341449297858921043 #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pdm_out,
    output logic             pdm_out_n,
    output logic             frame_start
);

    localparam logic [WIDTH-1:0] c_frame_last = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_one        = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_pending;
    logic             r_pending_full;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_frame_cnt;
    logic             r_pdm;
    logic             r_frame_start;

    logic             w_boundary;
    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_next_active;

    assign w_boundary    = (r_frame_cnt == c_frame_last);
    assign w_accept      = sample_valid && !r_pending_full;
    assign w_sum         = {1'b0, r_acc} + {1'b0, r_active};
    assign w_next_active = (w_boundary && r_pending_full) ? r_pending : r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_active       <= '0;
            r_acc          <= '0;
            r_frame_cnt    <= '0;
            r_pdm          <= 1'b0;
            r_frame_start  <= 1'b0;
        end else begin
            r_frame_cnt   <= r_frame_cnt + c_one;
            r_frame_start <= w_boundary;

            if (w_boundary) begin
                // Seeding acc with the new value is the frame's first addition
                // from zero; it can never carry, so bit 0 is always low.
                r_active <= w_next_active;
                r_acc    <= w_next_active;
                r_pdm    <= 1'b0;
                if (r_pending_full) begin
                    r_pending_full <= 1'b0;
                end
            end else begin
                r_acc <= w_sum[WIDTH-1:0];
                r_pdm <= w_sum[WIDTH];
            end

            // Only possible when the buffer was empty, so it never collides
            // with the boundary drain above.
            if (w_accept) begin
                r_pending      <= sample_in;
                r_pending_full <= 1'b1;
            end
        end
    end

    assign sample_ready = !r_pending_full;
    assign pdm_out      = r_pdm;
    assign pdm_out_n    = !r_pdm;
    assign frame_start  = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_anfsqrt_pdm_341449297858921043.sv
`default_nettype none
// ============================================================================
// Module   : tb_anfsqrt_pdm_341449297858921043
// Brief    : Directed, table-driven bench for the sigma-delta PDM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_anfsqrt_pdm_341449297858921043;

    logic       clk;
    logic       rst;
    logic [6:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       pdm_out;
    logic       pdm_out_n;
    logic       frame_start;

    int checks = 0;
    int errors = 0;
    int mon_cur;

    typedef struct {
        logic [6:0] value;
        int         highs;
        int         bit1;
        int         bit127;
    } vec_t;

    vec_t vecs[5];

    anfsqrt_pdm_341449297858921043 #(.WIDTH(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pdm_out      (pdm_out),
        .pdm_out_n    (pdm_out_n),
        .frame_start  (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // High-count of the frame in progress; at the frame_start sample point it
    // still holds the total of the frame that just ended.
    always @(negedge clk) begin
        if (rst)              mon_cur <= 0;
        else if (frame_start) mon_cur <= int'(pdm_out);
        else                  mon_cur <= mon_cur + int'(pdm_out);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pdm_out"},      int'(pdm_out),      0);
        check({tag, " pdm_out_n"},    int'(pdm_out_n),    1);
        check({tag, " frame_start"},  int'(frame_start),  0);
        check({tag, " sample_ready"}, int'(sample_ready), 1);
    endtask

    // Advances until frame_start is seen, returns the number of edges taken.
    task automatic wait_fs(input string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 300);
        if (!frame_start) check({name, " frame_start timeout"}, 0, 1);
    endtask

    // Call on a frame_start cycle; observes the full 128-bit frame and
    // returns on the next frame's first cycle.
    task automatic capture(input string name, input vec_t v);
        int highs   = 0;
        int bad_bit = 0;
        int bad_n   = 0;
        int bad_fs  = 0;
        int b1      = -1;
        int b127    = -1;
        int vi      = int'(v.value);
        for (int k = 0; k < 128; k++) begin
            int exp_bit = (k == 0) ? 0 : (((k + 1) * vi) / 128 - (k * vi) / 128);
            if (int'(pdm_out) != exp_bit)   bad_bit++;
            if (pdm_out_n !== !pdm_out)     bad_n++;
            if (frame_start !== (k == 0))   bad_fs++;
            if (k == 1)   b1   = int'(pdm_out);
            if (k == 127) b127 = int'(pdm_out);
            highs += int'(pdm_out);
            tick();
        end
        check({name, " highs"},          highs,   v.highs);
        check({name, " bit1"},           b1,      v.bit1);
        check({name, " bit127"},         b127,    v.bit127);
        check({name, " pattern errs"},   bad_bit, 0);
        check({name, " pdm_out_n errs"}, bad_n,   0);
        check({name, " frame_start errs"}, bad_fs, 0);
        check({name, " next frame_start"}, int'(frame_start), 1);
    endtask

    // Presents v for one edge on a cycle where the buffer must be empty.
    task automatic send(input string name, input logic [6:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        check({name, " ready before send"}, int'(sample_ready), 1);
        tick();
        sample_valid = 1'b0;
        check({name, " ready after send"}, int'(sample_ready), 0);
    endtask

    initial begin
        int   n;
        int   highs;
        vec_t v;

        vecs[0] = '{value: 7'h40, highs: 64,  bit1: 1, bit127: 1};
        vecs[1] = '{value: 7'h7F, highs: 127, bit1: 1, bit127: 1};
        vecs[2] = '{value: 7'h00, highs: 0,   bit1: 0, bit127: 0};
        vecs[3] = '{value: 7'h01, highs: 1,   bit1: 0, bit127: 1};
        vecs[4] = '{value: 7'h2A, highs: 42,  bit1: 0, bit127: 1};

        // Reset held with valid asserted
        rst          = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 7'h40;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_reset_outputs("reset hold");
        end

        rst = 1'b0;
        tick();
        sample_valid = 1'b0;
        check("accept on edge 1", int'(sample_ready), 0);
        n     = 1;
        highs = 0;
        while (!frame_start && n < 300) begin
            highs += int'(pdm_out);
            tick();
            n++;
        end
        check("first frame_start edge", n, 128);
        check("pre-frame highs", highs, 0);
        check("ready after first boundary", int'(sample_ready), 1);
        capture("vec0", vecs[0]);

        // Table: load each value, it becomes active one frame later
        for (int i = 1; i < 5; i++) begin
            send($sformatf("vec%0d", i), vecs[i].value);
            wait_fs($sformatf("vec%0d", i), n);
            check($sformatf("vec%0d load latency", i), n, 127);
            check($sformatf("vec%0d prior frame highs", i), mon_cur, vecs[i-1].highs);
            capture($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: 0x10 then 0x30 held
        sample_in    = 7'h10;
        sample_valid = 1'b1;
        tick();
        sample_in = 7'h30;
        check("bp stall ready", int'(sample_ready), 0);
        n = 0;
        while (!sample_ready && n < 300) begin
            tick();
            n++;
        end
        check("bp stall length", n, 127);
        check("bp release on frame_start", int'(frame_start), 1);
        check("bp frame before 0x10", mon_cur, 42);
        tick();
        sample_valid = 1'b0;
        check("bp 0x30 accepted", int'(sample_ready), 0);
        wait_fs("bp", n);
        check("bp 0x10 frame highs", mon_cur, 16);
        v = '{value: 7'h30, highs: 48, bit1: 0, bit127: 1};
        capture("bp 0x30", v);

        // Accept on the boundary edge with pending empty
        for (int i = 0; i < 127; i++) tick();
        check("sim cnt127 frame_start", int'(frame_start), 0);
        check("sim cnt127 ready", int'(sample_ready), 1);
        sample_in    = 7'h05;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("sim boundary frame_start", int'(frame_start), 1);
        check("sim held in pending", int'(sample_ready), 0);
        capture("sim persist 0x30", v);
        check("sim ready after next boundary", int'(sample_ready), 1);
        v = '{value: 7'h05, highs: 5, bit1: 0, bit127: 1};
        capture("sim 0x05", v);

        // Mid-frame reset with a pending sample that must be dropped
        send("mid 0x7F", 7'h7F);
        wait_fs("mid", n);
        send("mid pending", 7'h22);
        for (int i = 0; i < 59; i++) tick();
        check("mid pre-reset pdm high", int'(pdm_out), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("mid reset");
        n     = 0;
        highs = 0;
        do begin
            tick();
            n++;
            if (!frame_start) highs += int'(pdm_out);
        end while (!frame_start && n < 300);
        check("mid frame_start edge", n, 128);
        check("mid highs before boundary", highs, 0);
        v = '{value: 7'h00, highs: 0, bit1: 0, bit127: 0};
        capture("mid pending dropped", v);
        send("mid reload", 7'h7F);
        wait_fs("mid reload", n);
        capture("mid reload", vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
